// File: rtl/sifive_scope_tl_d_echo_tracer_pkg.sv
// Shared types and helpers for the TileLink D-channel echo trace probe.
package sifive_scope_tl_trace_pkg;

  localparam int DROP_W = 8;
  localparam int OPC_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'd0,
    MODE_FILL = 2'd1,
    MODE_WRAP = 2'd2,
    MODE_TRIG = 2'd3
  } mode_e;

  // Channel-index field width; a single-channel build still carries a 1-bit field.
  function automatic int ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  // Width of one packed trace record {ch, ts, opcode, source, echo}.
  function automatic int rec_w(input int num_ch, input int ts_w, input int src_w, input int echo_w);
    return ch_w(num_ch) + ts_w + OPC_W + src_w + echo_w;
  endfunction

endpackage

// File: rtl/sifive_scope_tl_d_echo_tracer_if.sv
// Snooped D-channel bundle plus the trace drain port.
interface sifive_scope_tl_d_echo_tracer_if
  import sifive_scope_tl_trace_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int ECHO_W = 4,
  parameter int SRC_W  = 4,
  parameter int TS_W   = 16
);

  localparam int REC_W = rec_w(NUM_CH, TS_W, SRC_W, ECHO_W);

  logic [NUM_CH-1:0]        mon_valid;
  logic [NUM_CH-1:0]        mon_ready;
  logic [NUM_CH*OPC_W-1:0]  mon_opcode;
  logic [NUM_CH*SRC_W-1:0]  mon_source;
  logic [NUM_CH*ECHO_W-1:0] mon_echo;

  logic                     out_valid;
  logic                     out_ready;
  logic [REC_W-1:0]         out_data;

  // Environment side: drives the snooped channels and consumes records.
  modport master (
    output mon_valid, mon_ready, mon_opcode, mon_source, mon_echo, out_ready,
    input  out_valid, out_data
  );

  // Tracer side: observes the channels and produces records.
  modport slave (
    input  mon_valid, mon_ready, mon_opcode, mon_source, mon_echo, out_ready,
    output out_valid, out_data
  );

endinterface

// File: rtl/sifive_scope_tl_d_echo_tracer_arb.sv
// Round-robin arbiter: one-hot grant, priority pointer moves past the winner.
module sifive_scope_rr_arb #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [N-1:0]     req,
  input  logic             upd_en,
  input  logic             clr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             found;
  int               idx;

  // Pick the first requester at or after the priority pointer.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr_q) + i) % N;
      if (!found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = IDX_W'(idx);
      end
    end
  end

  // Next pointer: one past the winner when the grant is consumed.
  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (upd_en && found) begin
      if (int'(gnt_idx) == N - 1) ptr_d = '0;
      else                        ptr_d = gnt_idx + IDX_W'(1);
    end
  end

  // Priority pointer register.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (!reset_n) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

endmodule

// File: rtl/sifive_scope_tl_d_echo_tracer.sv
// Passive multi-channel TileLink D echo tracer with fill/wrap/trigger capture.
module sifive_scope_tl_d_echo_tracer
  import sifive_scope_tl_trace_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int ECHO_W = 4,
  parameter int SRC_W  = 4,
  parameter int TS_W   = 16,
  parameter int DEPTH  = 16
) (
  input  logic                       clock,
  input  logic                       reset_n,
  sifive_scope_tl_d_echo_tracer_if.slave bus,
  input  logic [NUM_CH-1:0]          ch_enable,
  input  logic [1:0]                 cfg_mode,
  input  logic [ECHO_W-1:0]          cfg_trig_echo,
  input  logic [ECHO_W-1:0]          cfg_trig_mask,
  input  logic [$clog2(DEPTH)-1:0]   cfg_post_cnt,
  input  logic                       arm,
  input  logic                       disarm,
  output logic [1:0]                 sts_state,
  output logic [$clog2(DEPTH):0]     sts_count,
  output logic                       sts_trig_hit,
  output logic                       sts_overflow,
  output logic [DROP_W-1:0]          sts_drop_cnt
);

  localparam int             PTR_W    = $clog2(DEPTH);
  localparam int             CH_W     = ch_w(NUM_CH);
  localparam int             DROP_MAX = (1 << DROP_W) - 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  typedef struct packed {
    logic [CH_W-1:0]   ch;
    logic [TS_W-1:0]   ts;
    logic [OPC_W-1:0]  opcode;
    logic [SRC_W-1:0]  source;
    logic [ECHO_W-1:0] echo;
  } trace_rec_t;

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [ECHO_W-1:0] trig_echo_q, trig_echo_d;
  logic [ECHO_W-1:0] trig_mask_q, trig_mask_d;
  logic [PTR_W-1:0]  post_cfg_q, post_cfg_d;
  logic [PTR_W-1:0]  post_q, post_d;
  logic [PTR_W-1:0]  wr_q, wr_d;
  logic [PTR_W-1:0]  rd_q, rd_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [TS_W-1:0]   ts_q, ts_d;
  logic              trig_hit_q, trig_hit_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic [NUM_CH-1:0] fire;
  logic [NUM_CH-1:0] arb_gnt;
  logic [CH_W-1:0]   arb_idx;
  logic              capturing;
  logic              readable;
  logic              full;
  logic              wr_en;
  logic              arm_accept;
  logic              trig_match;
  logic              pop;
  int                n_fire;
  int                drop_sum;
  trace_rec_t        wr_rec;

  trace_rec_t        ram_q [DEPTH];

  assign fire       = bus.mon_valid & bus.mon_ready & ch_enable;
  assign n_fire     = $countones(fire);
  assign capturing  = (state_q == ST_ARMED) || (state_q == ST_POST);
  assign readable   = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign full       = (count_q == FULL_CNT);
  // A FILL capture that is already full stops writing; WRAP/TRIG overwrite the oldest entry.
  assign wr_en      = capturing && (|fire) && !((mode_q == MODE_FILL) && full);
  // disarm takes priority over a coincident arm.
  assign arm_accept = readable && arm && !disarm;
  assign trig_match = (((wr_rec.echo ^ trig_echo_q) & trig_mask_q) == '0);
  assign pop        = bus.out_valid && bus.out_ready;

  sifive_scope_rr_arb #(
    .N     (NUM_CH),
    .IDX_W (CH_W)
  ) u_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (fire),
    .upd_en  (wr_en),
    .clr     (arm_accept),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  // Assemble the record for the granted channel from its D-channel fields.
  always_comb begin
    wr_rec    = '0;
    wr_rec.ch = arb_idx;
    wr_rec.ts = ts_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (arb_gnt[c]) begin
        wr_rec.opcode = bus.mon_opcode[c*OPC_W +: OPC_W];
        wr_rec.source = bus.mon_source[c*SRC_W +: SRC_W];
        wr_rec.echo   = bus.mon_echo[c*ECHO_W +: ECHO_W];
      end
    end
  end

  // Capture FSM, ring pointers, timestamp and sticky status.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    trig_echo_d = trig_echo_q;
    trig_mask_d = trig_mask_q;
    post_cfg_d  = post_cfg_q;
    post_d      = post_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    count_d     = count_q;
    ts_d        = ts_q;
    trig_hit_d  = trig_hit_q;
    overflow_d  = overflow_q;
    drop_d      = drop_q;
    drop_sum    = 0;

    if (capturing) ts_d = ts_q + TS_W'(1);

    if (wr_en) begin
      wr_d = wr_q + PTR_W'(1);
      if (full) begin
        rd_d       = rd_q + PTR_W'(1);
        overflow_d = 1'b1;
      end else begin
        count_d = count_q + (PTR_W+1)'(1);
      end

      // Every fired channel that lost arbitration is a dropped beat.
      if (n_fire > 1) begin
        overflow_d = 1'b1;
        drop_sum   = int'(drop_q) + n_fire - 1;
        drop_d     = (drop_sum > DROP_MAX) ? DROP_W'(DROP_MAX) : DROP_W'(drop_sum);
      end

      case (mode_q)
        MODE_FILL: if (count_d == FULL_CNT) state_d = ST_DONE;
        MODE_TRIG: begin
          if (state_q == ST_ARMED) begin
            if (trig_match) begin
              trig_hit_d = 1'b1;
              post_d     = post_cfg_q;
              state_d    = (post_cfg_q == '0) ? ST_DONE : ST_POST;
            end
          end else begin
            // post_q counts the beats still owed after the trigger; this write consumes one.
            post_d = post_q - PTR_W'(1);
            if (post_q == PTR_W'(1)) state_d = ST_DONE;
          end
        end
        default: ;
      endcase
    end

    if (capturing && disarm) state_d = ST_IDLE;

    if (pop) begin
      rd_d    = rd_q + PTR_W'(1);
      count_d = count_q - (PTR_W+1)'(1);
    end

    if (arm_accept) begin
      wr_d        = '0;
      rd_d        = '0;
      count_d     = '0;
      ts_d        = '0;
      post_d      = '0;
      drop_d      = '0;
      overflow_d  = 1'b0;
      trig_hit_d  = 1'b0;
      mode_d      = mode_e'(cfg_mode);
      trig_echo_d = cfg_trig_echo;
      trig_mask_d = cfg_trig_mask;
      post_cfg_d  = cfg_post_cnt;
      state_d     = (mode_e'(cfg_mode) == MODE_OFF) ? ST_IDLE : ST_ARMED;
    end
  end

  // Control and status registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_OFF;
      trig_echo_q <= '0;
      trig_mask_q <= '0;
      post_cfg_q  <= '0;
      post_q      <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      count_q     <= '0;
      ts_q        <= '0;
      trig_hit_q  <= 1'b0;
      overflow_q  <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      trig_echo_q <= trig_echo_d;
      trig_mask_q <= trig_mask_d;
      post_cfg_q  <= post_cfg_d;
      post_q      <= post_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      count_q     <= count_d;
      ts_q        <= ts_d;
      trig_hit_q  <= trig_hit_d;
      overflow_q  <= overflow_d;
      drop_q      <= drop_d;
    end
  end

  // Trace storage write port.
  always_ff @(posedge clock) begin
    // NOTE: the RAM has no reset; count_q gates every read, so stale contents are never exposed.
    if (wr_en) ram_q[wr_q] <= wr_rec;
  end

  assign bus.out_valid = readable && (count_q != '0);
  assign bus.out_data  = ram_q[rd_q];

  assign sts_state    = state_q;
  assign sts_count    = count_q;
  assign sts_trig_hit = trig_hit_q;
  assign sts_overflow = overflow_q;
  assign sts_drop_cnt = drop_q;

endmodule

// File: tb/tb_sifive_scope_tl_d_echo_tracer.sv
// Scoreboard bench for the D-channel echo tracer.
module tb_sifive_scope_tl_d_echo_tracer;
  import sifive_scope_tl_trace_pkg::*;

  localparam int NUM_CH = 2;
  localparam int ECHO_W = 4;
  localparam int SRC_W  = 4;
  localparam int TS_W   = 16;
  localparam int DEPTH  = 16;
  localparam int PTR_W  = 4;
  localparam int REC_W  = 1 + TS_W + 3 + SRC_W + ECHO_W;

  logic              clock = 1'b0;
  logic              reset_n;
  logic [NUM_CH-1:0] ch_enable;
  logic [1:0]        cfg_mode;
  logic [ECHO_W-1:0] cfg_trig_echo;
  logic [ECHO_W-1:0] cfg_trig_mask;
  logic [PTR_W-1:0]  cfg_post_cnt;
  logic              arm;
  logic              disarm;
  logic [1:0]        sts_state;
  logic [PTR_W:0]    sts_count;
  logic              sts_trig_hit;
  logic              sts_overflow;
  logic [7:0]        sts_drop_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  int ts_exp   = 0;
  logic [REC_W-1:0] exp_q [$];

  sifive_scope_tl_d_echo_tracer_if #(
    .NUM_CH (NUM_CH), .ECHO_W (ECHO_W), .SRC_W (SRC_W), .TS_W (TS_W)
  ) bus ();

  sifive_scope_tl_d_echo_tracer #(
    .NUM_CH (NUM_CH), .ECHO_W (ECHO_W), .SRC_W (SRC_W), .TS_W (TS_W), .DEPTH (DEPTH)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .bus           (bus),
    .ch_enable     (ch_enable),
    .cfg_mode      (cfg_mode),
    .cfg_trig_echo (cfg_trig_echo),
    .cfg_trig_mask (cfg_trig_mask),
    .cfg_post_cnt  (cfg_post_cnt),
    .arm           (arm),
    .disarm        (disarm),
    .sts_state     (sts_state),
    .sts_count     (sts_count),
    .sts_trig_hit  (sts_trig_hit),
    .sts_overflow  (sts_overflow),
    .sts_drop_cnt  (sts_drop_cnt)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [2:0] opc_of(input logic [3:0] e);
    return e[2:0] ^ 3'd5;
  endfunction

  function automatic logic [3:0] src_of(input logic [3:0] e);
    return e ^ 4'hA;
  endfunction

  function automatic logic [REC_W-1:0] make_rec(input logic ch, input int ts, input logic [3:0] e);
    logic [15:0] t;
    t = 16'(ts);
    return {ch, t, opc_of(e), src_of(e), e};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
    ts_exp++;
  endtask

  task automatic drive_beats(input logic [1:0] vmask, input logic [1:0] rmask,
                             input logic [3:0] e0, input logic [3:0] e1);
    bus.mon_valid  = vmask;
    bus.mon_ready  = rmask;
    bus.mon_opcode = {opc_of(e1), opc_of(e0)};
    bus.mon_source = {src_of(e1), src_of(e0)};
    bus.mon_echo   = {e1, e0};
    tick();
    bus.mon_valid  = '0;
  endtask

  task automatic do_arm(input logic [1:0] mode, input logic [3:0] trig,
                        input logic [3:0] mask, input logic [3:0] post);
    cfg_mode      = mode;
    cfg_trig_echo = trig;
    cfg_trig_mask = mask;
    cfg_post_cnt  = post;
    arm           = 1'b1;
    tick();
    arm           = 1'b0;
    ts_exp        = 0;
  endtask

  task automatic do_disarm();
    disarm = 1'b1;
    tick();
    disarm = 1'b0;
  endtask

  // Pops every queued record against the drain port, one per cycle.
  task automatic drain(input string tag);
    int n;
    n = exp_q.size();
    bus.out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
      check({tag, "_data"}, 64'(bus.out_data), 64'(exp_q.pop_front()));
      tick();
    end
    bus.out_ready = 1'b0;
    check({tag, "_empty"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_count0"}, 64'(sts_count), 64'd0);
  endtask

  initial begin
    reset_n        = 1'b0;
    ch_enable      = 2'b11;
    cfg_mode       = 2'd0;
    cfg_trig_echo  = '0;
    cfg_trig_mask  = '0;
    cfg_post_cnt   = '0;
    arm            = 1'b0;
    disarm         = 1'b0;
    bus.mon_valid  = '0;
    bus.mon_ready  = '0;
    bus.mon_opcode = '0;
    bus.mon_source = '0;
    bus.mon_echo   = '0;
    bus.out_ready  = 1'b0;
    #12;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    tick();

    // Reset state
    check("rst_state", 64'(sts_state), 64'(ST_IDLE));
    check("rst_count", 64'(sts_count), 64'd0);
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_trig", 64'(sts_trig_hit), 64'd0);
    check("rst_ovf", 64'(sts_overflow), 64'd0);
    check("rst_drop", 64'(sts_drop_cnt), 64'd0);

    // Arm with mode OFF stays idle
    do_arm(2'd0, 4'h0, 4'h0, 4'h0);
    check("off_state", 64'(sts_state), 64'(ST_IDLE));

    // FILL: 20 beats, first 16 kept, DONE after the 16th
    do_arm(2'd1, 4'h0, 4'h0, 4'h0);
    check("fill_armed", 64'(sts_state), 64'(ST_ARMED));
    for (int i = 0; i < 20; i++) begin
      if (i < 16) exp_q.push_back(make_rec(1'b0, ts_exp, 4'(i)));
      drive_beats(2'b01, 2'b01, 4'(i), 4'h0);
      if (i == 15) begin
        check("fill_done", 64'(sts_state), 64'(ST_DONE));
        check("fill_cnt16", 64'(sts_count), 64'd16);
      end
    end
    check("fill_drop", 64'(sts_drop_cnt), 64'd0);
    check("fill_ovf", 64'(sts_overflow), 64'd0);
    check("fill_cnt", 64'(sts_count), 64'd16);
    drain("fill");

    // WRAP: 20 spaced beats, oldest 4 overwritten
    do_arm(2'd2, 4'h0, 4'h0, 4'h0);
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back(make_rec(1'b0, ts_exp, 4'(i)));
      drive_beats(2'b01, 2'b01, 4'(i), 4'h0);
      tick();
    end
    check("wrap_armed", 64'(sts_state), 64'(ST_ARMED));
    do_disarm();
    check("wrap_idle", 64'(sts_state), 64'(ST_IDLE));
    check("wrap_cnt", 64'(sts_count), 64'd16);
    check("wrap_ovf", 64'(sts_overflow), 64'd1);
    for (int i = 0; i < 4; i++) void'(exp_q.pop_front());
    drain("wrap");

    // TRIG: trigger on echo 9, three post beats
    do_arm(2'd3, 4'h9, 4'hF, 4'd3);
    for (int i = 0; i < 16; i++) begin
      if (i <= 12) exp_q.push_back(make_rec(1'b0, ts_exp, 4'(i)));
      drive_beats(2'b01, 2'b01, 4'(i), 4'h0);
      if (i == 8) check("trig_pre", 64'(sts_state), 64'(ST_ARMED));
      if (i == 9) begin
        check("trig_post", 64'(sts_state), 64'(ST_POST));
        check("trig_hit", 64'(sts_trig_hit), 64'd1);
      end
      if (i == 12) check("trig_done", 64'(sts_state), 64'(ST_DONE));
    end
    check("trig_cnt", 64'(sts_count), 64'd13);
    check("trig_drop", 64'(sts_drop_cnt), 64'd0);
    // Stall the consumer: head record must hold
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("stall_valid", 64'(bus.out_valid), 64'd1);
      check("stall_data", 64'(bus.out_data), 64'(exp_q[0]));
      tick();
    end
    // arm with disarm in DONE does nothing
    arm    = 1'b1;
    disarm = 1'b1;
    tick();
    arm    = 1'b0;
    disarm = 1'b0;
    check("armdis_state", 64'(sts_state), 64'(ST_DONE));
    check("armdis_cnt", 64'(sts_count), 64'd13);
    check("armdis_hit", 64'(sts_trig_hit), 64'd1);
    drain("trig");

    // Both channels fire together: alternate winners, losers dropped
    do_arm(2'd1, 4'h0, 4'h0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) exp_q.push_back(make_rec(1'b0, ts_exp, 4'(2*i)));
      else            exp_q.push_back(make_rec(1'b1, ts_exp, 4'(2*i+1)));
      drive_beats(2'b11, 2'b11, 4'(2*i), 4'(2*i+1));
    end
    // Disabled channel and a not-ready beat are both ignored
    ch_enable = 2'b10;
    drive_beats(2'b01, 2'b01, 4'hE, 4'h0);
    ch_enable = 2'b11;
    drive_beats(2'b10, 2'b01, 4'h0, 4'hD);
    check("dual_cnt", 64'(sts_count), 64'd4);
    check("dual_drop", 64'(sts_drop_cnt), 64'd4);
    check("dual_ovf", 64'(sts_overflow), 64'd1);
    check("dual_state", 64'(sts_state), 64'(ST_ARMED));
    do_disarm();
    drain("dual");

    // Async reset while in POST with 7 entries
    do_arm(2'd3, 4'hE, 4'h7, 4'd3);
    for (int i = 0; i < 7; i++) drive_beats(2'b01, 2'b01, 4'(i), 4'h0);
    check("pre_rst_state", 64'(sts_state), 64'(ST_POST));
    check("pre_rst_cnt", 64'(sts_count), 64'd7);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_state", 64'(sts_state), 64'(ST_IDLE));
    check("arst_cnt", 64'(sts_count), 64'd0);
    check("arst_valid", 64'(bus.out_valid), 64'd0);
    check("arst_hit", 64'(sts_trig_hit), 64'd0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    tick();
    check("post_rst_state", 64'(sts_state), 64'(ST_IDLE));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
